// File: rtl/vector_exec_sequencer.sv
// Vector execution sequencer: streams one element per cycle through a shared
// scalar ALU, collects the results, and reports completion, N/Z flags and a
// branch-taken indication for the finished vector operation.
module vector_exec_sequencer #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start_valid,
    output logic                                     start_ready,
    input  logic [2:0]                               ExecuteOp,
    input  logic                                     overwriteFlags,
    input  logic [2:0]                               pcWrEn,
    input  logic [vectorSize-1:0][registerSize-1:0] vect1,
    input  logic [vectorSize-1:0][registerSize-1:0] vect2,
    output logic [2:0]                               alu_op,
    output logic [registerSize-1:0]                  alu_a,
    output logic [registerSize-1:0]                  alu_b,
    input  logic [registerSize-1:0]                  alu_result,
    input  logic                                     alu_neg,
    input  logic                                     alu_zero,
    output logic [vectorSize-1:0][registerSize-1:0] vect_out,
    output logic                                     done,
    output logic                                     pcWrEn_out,
    output logic                                     neg_flag,
    output logic                                     zero_flag,
    output logic                                     stall
);

    localparam int IW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(vectorSize - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [2:0]                               op_q;
    logic                                     ovf_q;
    logic [2:0]                               pcsel_q;
    logic [vectorSize-1:0][registerSize-1:0] v1_q, v2_q;
    logic [vectorSize-1:0][registerSize-1:0] buffer, buffer_next;
    logic [IW-1:0]                            idx;
    logic                                     neg_acc, zero_acc;
    logic                                     neg_fin, zero_fin;
    logic                                     accept, last;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode, handshake, ALU drive and completion outputs
    always_comb begin
        state_next  = state;
        start_ready = 1'b1;
        accept      = 1'b0;
        last        = 1'b0;
        done        = 1'b0;
        pcWrEn_out  = 1'b0;
        alu_op      = '0;
        alu_a       = '0;
        alu_b       = '0;
        case (state)
            IDLE: begin
                accept = start_valid;
                if (accept) state_next = RUN;
            end
            RUN: begin
                start_ready = 1'b0;
                alu_op      = op_q;
                alu_a       = v1_q[idx];
                alu_b       = v2_q[idx];
                last        = (idx == LAST_IDX);
                if (last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                // Flags were written on the RUN->DONE edge, so the registered
                // values here are already the post-update ones.
                case (pcsel_q)
                    3'b100:  pcWrEn_out = 1'b1;
                    3'b010:  pcWrEn_out = zero_flag;
                    3'b001:  pcWrEn_out = neg_flag;
                    default: pcWrEn_out = 1'b0;
                endcase
                accept     = start_valid;
                state_next = accept ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
        stall = (state == RUN) || (start_valid && !start_ready);
    end

    // Buffer image including the element being produced this cycle, so the
    // final element lands in vect_out on the same edge as the rest.
    always_comb begin
        buffer_next      = buffer;
        buffer_next[idx] = alu_result;
        neg_fin          = neg_acc | alu_neg;
        zero_fin         = zero_acc & alu_zero;
    end

    // Operand capture, element stepping, result collection and flag update
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            ovf_q     <= 1'b0;
            pcsel_q   <= '0;
            v1_q      <= '0;
            v2_q      <= '0;
            buffer    <= '0;
            idx       <= '0;
            neg_acc   <= 1'b0;
            zero_acc  <= 1'b1;
            vect_out  <= '0;
            neg_flag  <= 1'b0;
            zero_flag <= 1'b0;
        end else if (state == RUN) begin
            buffer   <= buffer_next;
            neg_acc  <= neg_fin;
            zero_acc <= zero_fin;
            if (last) begin
                vect_out <= buffer_next;
                if (ovf_q) begin
                    neg_flag  <= neg_fin;
                    zero_flag <= zero_fin;
                end
            end else begin
                idx <= idx + IW'(1);
            end
        end else if (accept) begin
            op_q     <= ExecuteOp;
            ovf_q    <= overwriteFlags;
            pcsel_q  <= pcWrEn;
            v1_q     <= vect1;
            v2_q     <= vect2;
            idx      <= '0;
            neg_acc  <= 1'b0;
            zero_acc <= 1'b1;
        end
    end

endmodule

// File: doc/vector_exec_sequencer.md
VECTOR_EXEC_SEQUENCER -- requirements
Module: vector_exec_sequencer

Interface
REQ-001 Parameter registerSize, default 8, element width in bits.
REQ-002 Parameter vectorSize, default 4, elements per vector (>=2).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start_valid  in  1  new vector operation offered.
REQ-006 start_ready  out  1  sequencer can accept an operation.
REQ-007 ExecuteOp  in  3  ALU operation code for the offered operation.
REQ-008 overwriteFlags  in  1  operation updates the N/Z flags.
REQ-009 pcWrEn  in  3  branch condition select (100 always, 010 zero, 001 negative).
REQ-010 vect1, vect2  in  vectorSize x registerSize  operand vectors.
REQ-011 alu_op  out  3  operation code driven to the shared scalar ALU.
REQ-012 alu_a, alu_b  out  registerSize  element operands driven to the shared ALU.
REQ-013 alu_result  in  registerSize  combinational ALU result, same cycle.
REQ-014 alu_neg, alu_zero  in  1  combinational ALU element flags, same cycle.
REQ-015 vect_out  out  vectorSize x registerSize  completed result vector.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 pcWrEn_out  out  1  branch-taken indication, qualified by done.
REQ-018 neg_flag, zero_flag  out  1  architectural N and Z flags.
REQ-019 stall  out  1  upstream pipeline must hold.

Function
REQ-020 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-021 start_ready SHALL be 1 in IDLE and DONE, 0 in RUN; stall SHALL equal (state==RUN) or (start_valid and not start_ready).
REQ-022 Accept = start_valid & start_ready; on accept, ExecuteOp, overwriteFlags, pcWrEn, vect1, vect2 SHALL be captured, element index set to 0, next state RUN.
REQ-023 Inputs other than start_valid SHALL be ignored when not accepting; changes during RUN SHALL not affect the operation.
REQ-024 In RUN with index i: alu_op = captured op, alu_a = captured vect1[i], alu_b = captured vect2[i]; alu_result stored to internal buffer[i] at cycle end.
REQ-025 Per-operation accumulators: neg_acc = OR of alu_neg over all elements; zero_acc = AND of alu_zero over all elements.
REQ-026 Index SHALL increment by 1 per RUN cycle; at index vectorSize-1, next state DONE; no wrap beyond vectorSize-1.
REQ-027 On RUN->DONE: vect_out SHALL load the whole buffer, including the final element, atomically; vect_out is otherwise unchanged.
REQ-028 On RUN->DONE with captured overwriteFlags=1: neg_flag<=neg_acc, zero_flag<=zero_acc; with 0, flags SHALL hold.
REQ-029 In DONE: done=1 and pcWrEn_out = 1 for captured pcWrEn 100, zero_flag (post-update) for 010, neg_flag (post-update) for 001, 0 for any other code.
REQ-030 Outside DONE: done=0, pcWrEn_out=0.
REQ-031 DONE lasts one cycle; next state RUN on accept, else IDLE (back-to-back operations with no idle cycle).
REQ-032 Latency: accept at edge T -> done high in the cycle after edge T+vectorSize; throughput one operation per vectorSize+1 cycles.
REQ-033 In IDLE and DONE, alu_op, alu_a, alu_b SHALL be 0.

Reset
REQ-034 On reset: state IDLE, index 0, buffer 0, vect_out 0, neg_flag 0, zero_flag 0, done 0, pcWrEn_out 0, start_ready 1.
REQ-035 Reset asserted in RUN or DONE SHALL abort the operation: no done pulse, no flag or vect_out update.
REQ-036 Reset SHALL take priority over a simultaneous accept.

Verification
REQ-037 Bench ALU model: op 000 = wrapping add, neg = MSB, zero = (result==0); vect1={1,2,3,4}, vect2={1,1,1,1}, op 000, overwriteFlags=1 -> done exactly 5 cycles after accept, vect_out={2,3,4,5}, neg_flag=0, zero_flag=0.
REQ-038 vect1={0,0,0,0}, vect2={0,0,0,0}, overwriteFlags=1, pcWrEn=010 -> zero_flag=1, pcWrEn_out=1 during done; repeat with pcWrEn=001 -> pcWrEn_out=0.
REQ-039 vect1={0x7F,0,0,0}, vect2={1,0,0,0}, overwriteFlags=0 after a prior op set zero_flag=1 -> flags unchanged (neg_flag 0, zero_flag 1); vect_out[0]=0x80.
REQ-040 start_valid held high for two operations -> second accepted in first operation's DONE cycle; done pulses 5 cycles apart; stall high during both RUN phases.
REQ-041 Reset asserted at element index 2 -> next cycle IDLE, vect_out and flags 0, no done pulse; new operation then completes normally.
REQ-042 pcWrEn=011 and pcWrEn=100 -> pcWrEn_out=0 and 1 respectively during done, independent of flags.
